// File: rtl/mtm_alu_serial_rx.sv
// Serial command receiver for the ALU input path: deframes 11-bit sin frames, assembles
// the B/A operands, checks CRC-4, frame count and opcode, and offers one result per command.
module mtm_alu_serial_rx #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_a,
  output logic [DATA_W-1:0] res_b,
  output logic [2:0]        res_op,
  output logic [2:0]        res_err,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int NB     = DATA_W / 8;
  localparam int CNT_W  = $clog2(2 * NB + 2);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(2 * NB);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(2 * NB + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TYPE = 2'd1,
    S_DATA = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t              state;
  logic                is_ctl;
  logic [2:0]          bit_cnt;
  logic [7:0]          byte_sr;
  logic [2*DATA_W-1:0] opnd_sr;
  logic [CNT_W-1:0]    data_cnt;
  logic [3:0]          crc;
  logic                bad_stop;
  logic [IDLE_W-1:0]   idle_cnt;

  logic [2:0]          ctl_op;
  logic [3:0]          ctl_crc;
  logic [3:0]          crc_final;
  logic                ctl_done;
  logic                timeout_hit;
  logic                load_evt;
  logic                err_data;
  logic                err_crc;
  logic                err_op;
  logic [2:0]          new_err;
  logic [2:0]          new_op;
  logic [DATA_W-1:0]   new_a;
  logic [DATA_W-1:0]   new_b;

  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] b);
    logic [3:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = crc_bit(r, b[i]);
    return r;
  endfunction

  assign dbg_state = state;
  assign ctl_op    = byte_sr[6:4];
  assign ctl_crc   = byte_sr[3:0];

  // The command CRC closes with a constant 1 followed by the opcode bits.
  assign crc_final = crc_bit(crc_bit(crc_bit(crc_bit(crc, 1'b1), ctl_op[2]), ctl_op[1]),
                             ctl_op[0]);

  assign ctl_done    = (state == S_STOP) && is_ctl;
  assign timeout_hit = TIMEOUT_EN && (state == S_IDLE) && sin && (data_cnt != '0) &&
                       (idle_cnt == IDLE_LAST);
  assign load_evt    = ctl_done || timeout_hit;

  // In the CTL stop cycle sin is the stop bit itself.
  assign err_data = timeout_hit || (data_cnt != CNT_FULL) || bad_stop || !sin;
  assign err_crc  = (crc_final != ctl_crc);
  assign err_op   = !(ctl_op inside {3'b000, 3'b001, 3'b100, 3'b101});

  always_comb begin
    new_err = 3'b000;
    new_op  = ctl_op;
    new_a   = opnd_sr[DATA_W-1:0];
    new_b   = opnd_sr[2*DATA_W-1:DATA_W];
    if (err_data) begin
      new_err = 3'b100;
      new_op  = 3'b000;
      new_a   = '0;
      new_b   = '0;
    end else if (err_crc) begin
      new_err = 3'b010;
    end else if (err_op) begin
      new_err = 3'b001;
    end
  end

  // Deframer and command accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_ctl   <= 1'b0;
      bit_cnt  <= 3'd0;
      byte_sr  <= 8'd0;
      opnd_sr  <= '0;
      data_cnt <= '0;
      crc      <= 4'd0;
      bad_stop <= 1'b0;
      idle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!sin) begin
            state    <= S_TYPE;
            idle_cnt <= '0;
          end else if (timeout_hit) begin
            data_cnt <= '0;
            crc      <= 4'd0;
            bad_stop <= 1'b0;
            idle_cnt <= '0;
          end else if (TIMEOUT_EN && (data_cnt != '0)) begin
            idle_cnt <= idle_cnt + 1'b1;
          end else begin
            idle_cnt <= '0;
          end
        end
        S_TYPE: begin
          is_ctl  <= sin;
          bit_cnt <= 3'd7;
          state   <= S_DATA;
        end
        S_DATA: begin
          byte_sr <= {byte_sr[6:0], sin};
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) state <= S_STOP;
        end
        S_STOP: begin
          state <= S_IDLE;
          if (is_ctl) begin
            data_cnt <= '0;
            crc      <= 4'd0;
            bad_stop <= 1'b0;
          end else begin
            opnd_sr <= {opnd_sr[2*DATA_W-9:0], byte_sr};
            crc     <= crc_byte(crc, byte_sr);
            if (data_cnt != CNT_SAT) data_cnt <= data_cnt + 1'b1;
            if (!sin) bad_stop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result port: valid/ready handshake. A transfer happens in a cycle where res_valid and
  // res_ready are both high; fields hold while valid is waiting, and a result that arrives
  // while the held one is still unaccepted is dropped and flagged on overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      res_op    <= 3'd0;
      res_err   <= 3'd0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load_evt) begin
        if (res_valid && !res_ready) begin
          overrun <= 1'b1;
        end else begin
          res_valid <= 1'b1;
          res_a     <= new_a;
          res_b     <= new_b;
          res_op    <= new_op;
          res_err   <= new_err;
        end
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serial_rx.sv
// Bench for mtm_alu_serial_rx: directed cases on a 32-bit instance, randomized commands on
// 8-bit and 64-bit instances, all scored against a polynomial-division reference model.
module tb_mtm_alu_serial_rx;

  localparam int EW = 134;  // {a[63:0], b[63:0], op[2:0], err[2:0]}
  typedef logic [7:0] byteq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sin0, sin1, sin2;
  logic        rdy0, rdy1, rdy2;
  logic        valid0, valid1, valid2;
  logic        ovr_0, ovr_1, ovr_2;
  logic [31:0] a0, b0;
  logic [7:0]  a1, b1;
  logic [63:0] a2, b2;
  logic [2:0]  op0, op1, op2, err0, err1, err2;
  logic [1:0]  st0, st1, st2;

  mtm_alu_serial_rx #(.DATA_W(32), .TIMEOUT_CYC(20)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sin0), .res_valid(valid0), .res_ready(rdy0),
    .res_a(a0), .res_b(b0), .res_op(op0), .res_err(err0), .overrun(ovr_0), .dbg_state(st0));
  mtm_alu_serial_rx #(.DATA_W(8), .TIMEOUT_CYC(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin1), .res_valid(valid1), .res_ready(rdy1),
    .res_a(a1), .res_b(b1), .res_op(op1), .res_err(err1), .overrun(ovr_1), .dbg_state(st1));
  mtm_alu_serial_rx #(.DATA_W(64), .TIMEOUT_CYC(50)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sin(sin2), .res_valid(valid2), .res_ready(rdy2),
    .res_a(a2), .res_b(b2), .res_op(op2), .res_err(err2), .overrun(ovr_2), .dbg_state(st2));

  int checks = 0;
  int errors = 0;
  int vcyc0 = 0;
  int ovr0 = 0, ovr1 = 0, ovr2 = 0;
  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  logic [2:0] ops[4] = '{3'b000, 3'b001, 3'b100, 3'b101};

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // CRC as the remainder of (message * x^4) divided by x^4 + x + 1.
  function automatic logic [3:0] ref_crc(input byteq_t bytes, input logic [2:0] op);
    bit msg[$];
    int n;
    foreach (bytes[i]) for (int k = 7; k >= 0; k--) msg.push_back(bytes[i][k]);
    msg.push_back(1'b1);
    for (int k = 2; k >= 0; k--) msg.push_back(op[k]);
    n = msg.size();
    repeat (4) msg.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (msg[i]) begin
        msg[i]   = ~msg[i];
        msg[i+3] = ~msg[i+3];
        msg[i+4] = ~msg[i+4];
      end
    end
    return {msg[n], msg[n+1], msg[n+2], msg[n+3]};
  endfunction

  function automatic logic [7:0] good_ctl(input byteq_t bytes, input logic [2:0] op);
    return {1'b0, op, ref_crc(bytes, op)};
  endfunction

  function automatic logic [EW-1:0] ref_result(input int nb, input byteq_t bytes,
                                               input bit any_bad, input logic [7:0] ctl);
    logic [63:0] a, b;
    logic [2:0]  op, err;
    a = '0;
    b = '0;
    op = ctl[6:4];
    if (bytes.size() != 2 * nb || any_bad) begin
      err = 3'b100;
    end else begin
      for (int i = 0; i < nb; i++) b = (b << 8) | 64'(bytes[i]);
      for (int i = nb; i < 2 * nb; i++) a = (a << 8) | 64'(bytes[i]);
      if (ref_crc(bytes, op) != ctl[3:0]) err = 3'b010;
      else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) err = 3'b001;
      else err = 3'b000;
    end
    return {a, b, (err[2] ? 3'b000 : op), err};
  endfunction

  function automatic logic [EW-1:0] pack_obs(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] op, input logic [2:0] err);
    return {a, b, (err[2] ? 3'b000 : op), err};
  endfunction

  function automatic byteq_t mk_bytes(input int nb, input logic [63:0] b, input logic [63:0] a);
    byteq_t q;
    for (int i = nb - 1; i >= 0; i--) q.push_back(b[8*i +: 8]);
    for (int i = nb - 1; i >= 0; i--) q.push_back(a[8*i +: 8]);
    return q;
  endfunction

  function automatic int nb_of(input int u);
    return (u == 0) ? 4 : (u == 1) ? 1 : 8;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic take(input int u, input logic [EW-1:0] obs);
    logic [EW-1:0] e;
    int n;
    n = (u == 0) ? exp_q0.size() : (u == 1) ? exp_q1.size() : exp_q2.size();
    check($sformatf("pending_u%0d", u), EW'(n != 0), EW'(1));
    if (n != 0) begin
      case (u)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check($sformatf("result_u%0d", u), obs, e);
    end
  endtask

  always @(negedge clk) begin
    if (valid0) vcyc0++;
    if (ovr_0) ovr0++;
    if (ovr_1) ovr1++;
    if (ovr_2) ovr2++;
    if (valid0 && rdy0) take(0, pack_obs(64'(a0), 64'(b0), op0, err0));
    if (valid1 && rdy1) take(1, pack_obs(64'(a1), 64'(b1), op1, err1));
    if (valid2 && rdy2) take(2, pack_obs(a2, b2, op2, err2));
  end

  // ---------------- drivers ----------------
  task automatic drive_bit(input int u, input logic b);
    @(posedge clk);
    #1;
    case (u)
      0: sin0 = b;
      1: begin
        sin1 = b;
        if (rdy_rand) rdy1 = rdy_force ? 1'b1 : 1'($urandom_range(0, 1));
      end
      default: begin
        sin2 = b;
        if (rdy_rand) rdy2 = rdy_force ? 1'b1 : 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  task automatic idle(input int u, input int n);
    repeat (n) drive_bit(u, 1'b1);
  endtask

  task automatic send_frame(input int u, input logic typ, input logic [7:0] d, input logic stop);
    drive_bit(u, 1'b0);
    drive_bit(u, typ);
    for (int k = 7; k >= 0; k--) drive_bit(u, d[k]);
    drive_bit(u, stop);
  endtask

  task automatic push_exp(input int u, input logic [EW-1:0] e);
    case (u)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // bad_idx: frame index with a bad stop bit (q.size() = CTL frame), -1 = none
  task automatic send_cmd(input int u, input byteq_t q, input logic [7:0] ctl,
                          input int bad_idx, input bit push);
    if (push) push_exp(u, ref_result(nb_of(u), q, bad_idx >= 0, ctl));
    foreach (q[i]) begin
      rdy_force = (i == 0);
      send_frame(u, 1'b0, q[i], i != bad_idx);
      idle(u, $urandom_range(0, 1));
    end
    rdy_force = (q.size() == 0);
    send_frame(u, 1'b1, ctl, bad_idx != q.size());
    rdy_force = 1'b0;
  endtask

  task automatic rand_cmd(input int u);
    int nb, n, kind, bad_idx;
    byteq_t q;
    logic [2:0] op;
    logic [7:0] ctl;
    nb = nb_of(u);
    kind = $urandom_range(0, 99);
    n = 2 * nb;
    bad_idx = -1;
    if (kind >= 75 && kind < 82) begin
      do n = $urandom_range(0, 2 * nb + 2); while (n == 2 * nb);
    end
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    op = (kind < 55) ? ops[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
    ctl = good_ctl(q, op);
    if (kind >= 65 && kind < 75) ctl[3:0] = ctl[3:0] ^ 4'($urandom_range(1, 15));
    if (kind >= 82 && kind < 90 && n > 0) bad_idx = $urandom_range(0, n - 1);
    if (kind >= 90 && kind < 95) bad_idx = n;
    if (kind >= 95) ctl = {1'b0, 7'($urandom_range(0, 127))};
    send_cmd(u, q, ctl, bad_idx, 1'b1);
    idle(u, $urandom_range(0, 3));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    byteq_t q;
    int snap;
    rst_n = 1'b0;
    sin0 = 1'b1; sin1 = 1'b1; sin2 = 1'b1;
    rdy0 = 1'b0; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", EW'({valid0, valid1, valid2}), EW'(0));
    check("rst_fields0", EW'({a0, b0, op0, err0, ovr_0}), EW'(0));
    rst_n = 1'b1;
    rdy0 = 1'b1;
    idle(0, 3);

    // basic command, ready high: one-cycle valid
    snap = vcyc0;
    q = mk_bytes(4, 64'd2, 64'd5);
    send_cmd(0, q, good_ctl(q, 3'b000), -1, 1'b1);
    idle(0, 5);
    check("valid_one_cycle", EW'(vcyc0 - snap), EW'(1));

    // wrong CRC
    send_cmd(0, q, 8'h40, -1, 1'b1);
    idle(0, 3);

    // short command
    q = '{8'h55, 8'h0F};
    send_cmd(0, q, 8'h50, -1, 1'b1);
    idle(0, 3);

    // extreme operands over every legal op, then an illegal op
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 4; k++) begin
        q = mk_bytes(4, (v == 0) ? 64'hFFFF_FFFF : 64'd0, (v == 0) ? 64'hFFFF_FFFF : 64'd0);
        send_cmd(0, q, good_ctl(q, ops[k]), -1, 1'b1);
        idle(0, 2);
      end
    end
    q = mk_bytes(4, 64'h1234_5678, 64'h9ABC_DEF0);
    send_cmd(0, q, good_ctl(q, 3'b010), -1, 1'b1);
    idle(0, 3);

    // backpressure and overrun
    rdy0 = 1'b0;
    snap = ovr0;
    q = mk_bytes(4, 64'h1122_3344, 64'h5566_7788);
    send_cmd(0, q, good_ctl(q, 3'b100), -1, 1'b1);
    idle(0, 2);
    q = mk_bytes(4, 64'd1, 64'd1);
    send_cmd(0, q, good_ctl(q, 3'b000), -1, 1'b0);
    idle(0, 3);
    check("ovr_pulse", EW'(ovr0 - snap), EW'(1));
    check("held_valid", EW'(valid0), EW'(1));
    check("held_a", EW'(a0), EW'(32'h5566_7788));
    check("held_b", EW'(b0), EW'(32'h1122_3344));
    check("held_op_err", EW'({op0, err0}), EW'({3'b100, 3'b000}));
    rdy0 = 1'b1;
    idle(0, 3);
    check("valid_drop", EW'(valid0), EW'(0));
    check("accept_drain", EW'(exp_q0.size()), EW'(0));

    // inter-frame timeout, then a clean command
    push_exp(0, EW'(3'b100));
    for (int i = 0; i < 3; i++) send_frame(0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    idle(0, 25);
    q = mk_bytes(4, 64'hCAFE_0001, 64'h0000_BEEF);
    send_cmd(0, q, good_ctl(q, 3'b101), -1, 1'b1);
    idle(0, 4);
    check("timeout_drain", EW'(exp_q0.size()), EW'(0));

    // reset in the middle of a frame while a result is held
    rdy0 = 1'b0;
    q = mk_bytes(4, 64'hA5A5_A5A5, 64'h5A5A_5A5A);
    send_cmd(0, q, good_ctl(q, 3'b001), -1, 1'b1);
    idle(0, 2);
    check("held_before_rst", EW'(valid0), EW'(1));
    send_frame(0, 1'b0, 8'hAA, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", EW'(valid0), EW'(0));
    check("mid_rst_ab", EW'({a0, b0}), EW'(0));
    check("mid_rst_op_err_ovr", EW'({op0, err0, ovr_0}), EW'(0));
    exp_q0.delete();
    sin0 = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy0 = 1'b1;
    idle(0, 3);
    q = mk_bytes(4, 64'h0000_0007, 64'h0000_0003);
    send_cmd(0, q, good_ctl(q, 3'b100), -1, 1'b1);
    idle(0, 4);
    check("post_rst_drain", EW'(exp_q0.size()), EW'(0));
    check("ovr_total_u0", EW'(ovr0), EW'(1));

    // randomized commands on the 8-bit and 64-bit instances
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) rand_cmd(1);
    for (int i = 0; i < 100; i++) rand_cmd(2);
    rdy_rand = 1'b0;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    idle(1, 5);
    check("drain_u1", EW'(exp_q1.size()), EW'(0));
    check("drain_u2", EW'(exp_q2.size()), EW'(0));
    check("ovr_u1", EW'(ovr1), EW'(0));
    check("ovr_u2", EW'(ovr2), EW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
